sqrt_job_host: RTL and testbench

- Synthesizable initiator for the program-3 (integer square root) start/halt protocol of TopLevel.
- Preloads the 16-bit operand into TopLevel data memory, holds start high, then releases it.
- Waits for halt, then reads the 8-bit result back.
- Checks the result against an internal bit-serial reference square root and reports pass/fail/timeout to a host.

---
 rtl/sqrt_job_host.sv | 217 +++++++++++++++++++++
 tb/tb_sqrt_job_host.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_job_host.sv
// Host-side initiator for the integer square-root job: loads the operand, starts the core,
// waits for halt (with timeout), reads the result back and compares it to a local reference.
module sqrt_job_host #(
  parameter logic [7:0] OP_ADDR      = 8'd16,
  parameter logic [7:0] RES_ADDR     = 8'd18,
  parameter int         START_CYCLES = 4,
  parameter int         TIMEOUT      = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        go,
  input  logic [15:0] operand,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timed_out,
  output logic [7:0]  expected,
  output logic [7:0]  got,
  output logic        start,
  input  logic        halt,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data
);

  localparam int CW = $clog2(TIMEOUT + START_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_HI, S_WR_LO, S_WR_RES, S_START, S_WAIT, S_READ, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic [15:0]     op_q, op_d;
  logic [7:0]      got_q, got_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            to_q, to_d;
  logic            done_q, done_d;

  logic [15:0]     rx_q, rx_d;
  logic [10:0]     rrem_q, rrem_d;
  logic [7:0]      rroot_q, rroot_d;
  logic [3:0]      rcnt_q, rcnt_d;
  logic [7:0]      exp_q, exp_d;

  logic            go_accept;
  logic            ref_busy;
  logic            job_ok;
  logic [10:0]     rem_sh, trial, rem_nx;
  logic [7:0]      root_nx, root_rnd;
  logic            ge;

  assign go_accept = (state_q == S_IDLE) && go;
  assign ref_busy  = (rcnt_q != 4'd0);
  assign job_ok    = (got_q == exp_q) && !to_q;

  // Restoring bit-pair square root, one operand bit pair per cycle, rounded and saturated.
  always_comb begin
    rx_d    = rx_q;
    rrem_d  = rrem_q;
    rroot_d = rroot_q;
    rcnt_d  = rcnt_q;
    exp_d   = exp_q;
    rem_sh  = {rrem_q[8:0], rx_q[15:14]};
    trial   = {1'b0, rroot_q, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = {rroot_q[6:0], ge};
    if (rem_nx > {3'b000, root_nx}) begin
      root_rnd = (root_nx == 8'hFF) ? 8'hFF : (root_nx + 8'd1);
    end else begin
      root_rnd = root_nx;
    end
    if (go_accept) begin
      rx_d    = operand;
      rrem_d  = '0;
      rroot_d = '0;
      rcnt_d  = 4'd8;
    end else if (ref_busy) begin
      rx_d    = {rx_q[13:0], 2'b00};
      rrem_d  = rem_nx;
      rroot_d = root_nx;
      rcnt_d  = rcnt_q - 4'd1;
      if (rcnt_q == 4'd1) exp_d = root_rnd;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    op_d        = op_q;
    got_d       = got_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    to_d        = to_q;
    done_d      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = 8'h00;
    mem_wr_data = 8'h00;
    start       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          op_d    = operand;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          got_d   = 8'h00;
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = OP_ADDR;
        mem_wr_data = op_q[15:8];
        state_d     = S_WR_LO;
      end
      S_WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = OP_ADDR + 8'd1;
        mem_wr_data = op_q[7:0];
        state_d     = S_WR_RES;
      end
      S_WR_RES: begin
        mem_wr_en   = 1'b1;
        mem_addr    = RES_ADDR;
        mem_wr_data = 8'h00;
        cnt_d       = CW'(START_CYCLES - 1);
        state_d     = S_START;
      end
      S_START: begin
        start = 1'b1;
        // A halt still high in the last start cycle is stale and must drop before it counts.
        armed_d = !halt;
        if (cnt_q == '0) begin
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT: begin
        if (halt && armed_q) begin
          state_d = S_READ;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          fail_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!halt) armed_d = 1'b1;
        end
      end
      S_READ: begin
        mem_addr = RES_ADDR;
        got_d    = mem_rd_data;
        state_d  = S_FIN;
      end
      S_FIN: begin
        if (!ref_busy) begin
          pass_d  = job_ok;
          fail_d  = !job_ok;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      op_q    <= '0;
      got_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      rrem_q  <= '0;
      rroot_q <= '0;
      rcnt_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      op_q    <= op_d;
      got_q   <= got_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      rrem_q  <= rrem_d;
      rroot_q <= rroot_d;
      rcnt_q  <= rcnt_d;
      exp_q   <= exp_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timed_out = to_q;
  assign expected  = exp_q;
  assign got       = got_q;

endmodule

// File: tb/tb_sqrt_job_host.sv
// Directed bench for sqrt_job_host with a behavioural core model (memory + halt) and a result scoreboard.
module tb_sqrt_job_host;

  localparam int TB_TIMEOUT = 200;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        go;
  logic [15:0] operand;
  logic        busy, done, pass, fail, timed_out;
  logic [7:0]  expected, got;
  logic        start;
  logic        halt;
  logic        mem_wr_en;
  logic [7:0]  mem_addr, mem_wr_data, mem_rd_data;

  sqrt_job_host #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .go(go), .operand(operand),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
    .expected(expected), .got(got), .start(start), .halt(halt),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] e_exp;
    logic [7:0] e_got;
    logic       e_pass;
    logic       e_fail;
    logic       e_to;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] wlog[$];
  logic [7:0]  mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          model_mode = 0;   // 0: answer after 3 cycles, 1: never halt, 2: halt stuck high
  logic [7:0]  model_res = 8'h00;
  logic        start_prev;
  int          hcnt;

  assign mem_rd_data = mem[mem_addr];

  // Core model: data memory, start-run length, delayed halt with result write.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wlog.push_back({mem_addr, mem_wr_data});
    end
    if (Reset) begin
      halt       <= 1'b0;
      start_prev <= 1'b0;
      hcnt       <= 0;
    end else begin
      start_prev <= start;
      if (start && !start_prev) begin
        start_cnt <= 1;
        halt      <= (model_mode == 2);
      end else if (start) begin
        start_cnt <= start_cnt + 1;
      end
      if (start_prev && !start && model_mode == 0) hcnt <= 3;
      else if (hcnt > 0) begin
        hcnt <= hcnt - 1;
        if (hcnt == 1) begin
          mem[8'd18] <= model_res;
          halt       <= 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] ref_round(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    if (x - r * r > r) r++;
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exv);
    checks++;
    assert (obs === exv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
    end
  endtask

  task automatic run_job(input logic [15:0] op, input logic [7:0] res, input int mode,
                         input bit inject);
    exp_t e;
    int   go_cyc;
    int   dc;
    bit   seen;
    e.e_exp  = ref_round(int'(op));
    e.e_to   = (mode != 0);
    e.e_got  = e.e_to ? 8'h00 : res;
    e.e_pass = !e.e_to && (res == e.e_exp);
    e.e_fail = !e.e_pass;
    model_res  = res;
    model_mode = mode;
    wlog.delete();
    @(negedge CLK);
    operand = op;
    go      = 1'b1;
    sb.push_back(e);
    go_cyc = cyc;
    dc     = done_cnt;
    @(negedge CLK);
    go = 1'b0;
    if (inject) begin
      @(negedge CLK);
      operand = 16'h1000;
      go      = 1'b1;
      @(negedge CLK);
      go = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      errors++;
      checks++;
      $error("FAIL done_wait: observed no done expected done within 2000 cycles");
    end else begin
      check("expected", expected, e.e_exp);
      check("got", got, e.e_got);
      check("pass", pass, e.e_pass);
      check("fail", fail, e.e_fail);
      check("timed_out", timed_out, e.e_to);
      check("busy_at_done", busy, 1'b0);
      check("writes", wlog.size(), 3);
      check("start_cycles", start_cnt, 4);
      if (mode != 0) check("timeout_latency", cyc - go_cyc, TB_TIMEOUT + 9);
      @(negedge CLK);
      check("done_pulse", done, 1'b0);
      check("pass_sticky", pass, e.e_pass);
      if (inject) begin
        repeat (20) @(negedge CLK);
        check("done_count", done_cnt - dc, 1);
        check("busy_after", busy, 1'b0);
      end
    end
  endtask

  initial begin
    int n;
    bit seen;
    Reset   = 1'b1;
    go      = 1'b0;
    operand = 16'h0000;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_timed_out", timed_out, 1'b0);
    check("rst_expected", expected, 8'h00);
    check("rst_got", got, 8'h00);
    check("rst_start", start, 1'b0);
    check("rst_mem_wr_en", mem_wr_en, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wr_data", mem_wr_data, 8'h00);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);

    run_job(16'h00F1, 8'h10, 0, 1'b0);
    check("w0", wlog[0], 16'h1000);
    check("w1", wlog[1], 16'h11F1);
    check("w2", wlog[2], 16'h1200);
    run_job(16'hFFFF, 8'hFF, 0, 1'b0);
    run_job(16'h0000, 8'h01, 0, 1'b0);
    run_job(16'd2, 8'h01, 0, 1'b0);
    run_job(16'd6, 8'h02, 0, 1'b0);
    run_job(16'd7, 8'h03, 0, 1'b0);
    run_job(16'd65281, 8'hFF, 0, 1'b0);
    run_job(16'd1234, 8'h00, 1, 1'b0);
    run_job(16'd1234, 8'h00, 2, 1'b0);

    // Reset in the middle of the start window.
    model_mode = 1;
    wlog.delete();
    @(negedge CLK);
    operand = 16'd999;
    go      = 1'b1;
    @(negedge CLK);
    go   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (start) seen = 1'b1;
    end
    check("saw_start", seen, 1'b1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("rst_mid_start", start, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    n = wlog.size();
    repeat (20) @(negedge CLK);
    check("rst_mid_writes", wlog.size(), n);
    check("rst_mid_start_idle", start, 1'b0);
    run_job(16'd144, 8'h0C, 0, 1'b0);

    // Second go while busy must be ignored.
    run_job(16'h0031, 8'h07, 0, 1'b1);
    check("inj_w0", wlog[0], 16'h1000);
    check("inj_w1", wlog[1], 16'h1131);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
